// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_t          - frame FSM state encoding (IDLE, START, DATA, STOP)
//   DEFAULT_CLKS_PER_BIT  - 50 MHz clock / 115200 baud
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: restartable bit-period counter.
//   clk         in   clock
//   reset       in   asynchronous active-high reset
//   restart_i   in   hold the counter at 0 (the next bit period starts afresh)
//   bit_tick_o  out  one-cycle pulse on the last cycle of every bit period
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic bit_tick_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrapping at CNT_MAX makes consecutive bit periods exactly
    // CLKS_PER_BIT cycles with no accumulated drift.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = (cnt_q == CNT_MAX) && !restart_i;

endmodule

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: UART transmitter that pulls words from a show-ahead FIFO.
//   clk           in   clock, all logic on the rising edge
//   reset         in   asynchronous active-high reset, aborts any frame
//   tx_en         in   permits starting new frames (running frames always finish)
//   fifo_empty    in   source FIFO empty flag
//   fifo_rd_data  in   FIFO head word, valid while fifo_empty is low
//   fifo_rd       out  one-cycle pop strobe, asserted in the cycle the word is loaded
//   tx            out  serial line (registered), idle high, LSB first
//   tx_busy       out  high from the cycle after the load through the last stop bit
//   tx_done       out  one-cycle pulse on the final cycle of the last stop bit
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    uart_state_t           state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic                  tx_q;
    logic                  armed_q;
    logic                  bit_tick;
    logic                  frame_end;
    logic                  load;

    // The counter is parked at 0 while idle, so START always gets a full
    // bit period. Every other state change happens on bit_tick, where the
    // counter wraps to 0 by itself.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .reset      (reset),
        .restart_i  (state_q == IDLE),
        .bit_tick_o (bit_tick)
    );

    assign frame_end = (state_q == STOP) && bit_tick && (bit_cnt_q == LAST_STOP);

    // armed_q is cleared by reset and set on the first edge after release,
    // so no pop can be issued while reset is high or before that edge.
    // A load is possible only from IDLE or on the very last stop-bit cycle,
    // which limits pops to one per frame.
    assign load = armed_q && tx_en && !fifo_empty &&
                  ((state_q == IDLE) || frame_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (load) begin
                // The word is captured here; later FIFO changes cannot
                // reach the frame in flight.
                shift_q   <= fifo_rd_data;
                bit_cnt_q <= '0;
                tx_q      <= 1'b0;
                state_q   <= START;
            end else begin
                case (state_q)
                    IDLE: begin
                        tx_q <= 1'b1;
                    end
                    START: begin
                        if (bit_tick) begin
                            tx_q    <= shift_q[0];
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (bit_tick) begin
                            if (bit_cnt_q == LAST_DATA) begin
                                tx_q      <= 1'b1;
                                bit_cnt_q <= '0;
                                state_q   <= STOP;
                            end else begin
                                // Present the next bit in the same edge as the shift.
                                shift_q   <= shift_q >> 1;
                                tx_q      <= shift_q[1];
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        if (bit_tick) begin
                            if (bit_cnt_q == LAST_STOP) begin
                                bit_cnt_q <= '0;
                                state_q   <= IDLE;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        tx_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign fifo_rd = load;
    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);
    assign tx_done = frame_end;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: scoreboard bench for uart_fifo_tx (8 data bits, 4 clocks
// per bit). A second instance with two stop bits is exercised at the end.
module tb_uart_fifo_tx;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (1 + DW + 1) * CPB;
    localparam int LAST  = FRAME - 1;

    logic       clk;
    logic       reset;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    logic       f2_empty;
    logic [7:0] f2_data;
    logic       f2_rd;
    logic       tx2;
    logic       busy2;
    logic       done2;

    // Source FIFO model: stimulus writes, monitor pops.
    logic [7:0] fmem [0:255];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_rd_data = fmem[rd_ptr];

    logic [7:0] exp_q [$];

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;

    int         mon_k        = -1;
    logic [7:0] mon_exp      = 8'h00;
    logic [7:0] mon_rx       = 8'h00;
    int         wave_err     = 0;
    int         busy_err     = 0;
    int         done_cnt     = 0;
    int         done_bad     = 0;
    int         pop_cyc      = -10;
    int         prev_pop_cyc = -10;
    int         pop_total    = 0;
    int         frame_end_cyc = -10;
    int         last_gap     = 0;

    uart_fifo_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_en        (tx_en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd      (fifo_rd),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    uart_fifo_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .tx_en        (1'b1),
        .fifo_empty   (f2_empty),
        .fifo_rd_data (f2_data),
        .fifo_rd      (f2_rd),
        .tx           (tx2),
        .tx_busy      (busy2),
        .tx_done      (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        assertions++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Line level expected k cycles into a frame: start 0, data LSB first, then stop 1s.
    function automatic logic exp_level(input logic [7:0] b, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= DW) return b[idx-1];
        return 1'b1;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b, input bit expect_tx);
        fmem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
        if (expect_tx) exp_q.push_back(b);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_k >= 0) && n < max_cyc) begin
            step(1);
            n++;
        end
        chk(exp_q.size() == 0 && mon_k < 0, "drain_pending", exp_q.size(), 0);
    endtask

    task automatic wait_k(input int target, input string name);
        int n;
        n = 0;
        while (mon_k < target && n < 200) begin
            step(1);
            n++;
        end
        chk(mon_k >= target, name, mon_k, target);
    endtask

    // Monitor: decodes each frame on tx and checks it against the next
    // expected byte; also pops the FIFO model after each fifo_rd.
    initial begin
        bit   pend;
        int   idx;
        wr_ptr = 8'd0;
        rd_ptr = 8'd0;
        forever begin
            @(negedge clk);
            pend = 1'b0;
            if (reset) begin
                mon_k = -1;
                chk(fifo_rd == 1'b0, "rd_in_reset", fifo_rd, 0);
            end else begin
                if (fifo_rd) begin
                    chk(!fifo_empty, "rd_while_empty", fifo_empty, 0);
                    chk(mon_k < 0 || mon_k == LAST, "rd_mid_frame", mon_k, LAST);
                    pend = 1'b1;
                    prev_pop_cyc = pop_cyc;
                    pop_cyc = cyc;
                    pop_total++;
                end
                if (mon_k < 0) begin
                    if (tx == 1'b0) begin
                        chk(cyc == pop_cyc + 1, "start_latency", cyc - pop_cyc, 1);
                        if (exp_q.size() == 0) begin
                            chk(1'b0 == tx, "unexpected_frame", 1, 0);
                            mon_exp = 8'h00;
                        end else begin
                            mon_exp = exp_q.pop_front();
                        end
                        last_gap = cyc - frame_end_cyc;
                        mon_k    = 0;
                        mon_rx   = 8'h00;
                        wave_err = 0;
                        busy_err = 0;
                        done_cnt = 0;
                        done_bad = 0;
                    end else begin
                        chk(tx_busy == 1'b0, "busy_idle", tx_busy, 0);
                        chk(tx_done == 1'b0, "done_idle", tx_done, 0);
                    end
                end
                if (mon_k >= 0) begin
                    if (tx !== exp_level(mon_exp, mon_k)) wave_err++;
                    if (tx_busy !== 1'b1) busy_err++;
                    if (tx_done) begin
                        if (mon_k == LAST) done_cnt++;
                        else done_bad++;
                    end
                    idx = mon_k / CPB;
                    if ((mon_k % CPB) == CPB / 2 && idx >= 1 && idx <= DW) mon_rx[idx-1] = tx;
                    if (mon_k == LAST) begin
                        chk(mon_rx == mon_exp, "frame_data", mon_rx, mon_exp);
                        chk(wave_err == 0, "frame_wave_errs", wave_err, 0);
                        chk(busy_err == 0, "frame_busy_errs", busy_err, 0);
                        chk(done_cnt == 1 && done_bad == 0, "frame_done", done_cnt + 16 * done_bad, 1);
                        frame_end_cyc = cyc;
                        mon_k = -1;
                    end else begin
                        mon_k++;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (pend) rd_ptr = rd_ptr + 8'd1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        int lows;
        int n;
        bit found;
        int w_err, b_err, done_n, done_at, stop_hi, pops2;
        logic [7:0] rb;

        reset    = 1'b1;
        tx_en    = 1'b0;
        f2_empty = 1'b1;
        f2_data  = 8'h00;
        step(2);
        chk(tx == 1'b1, "reset_tx", tx, 1);
        chk(tx_busy == 1'b0, "reset_busy", tx_busy, 0);
        chk(tx_done == 1'b0, "reset_done", tx_done, 0);
        chk(fifo_rd == 1'b0, "reset_rd", fifo_rd, 0);
        reset = 1'b0;
        step(2);

        // Empty FIFO with enable: line must stay idle, no pops.
        tx_en = 1'b1;
        snap = pop_total;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        step(1);
        chk(lows == 0, "empty_tx_low_cycles", lows, 0);
        chk(pop_total == snap, "empty_pops", pop_total - snap, 0);

        // Single byte.
        snap = pop_total;
        push(8'hA5, 1'b1);
        drain(200);
        chk(pop_total - snap == 1, "single_pops", pop_total - snap, 1);

        // Back-to-back frames.
        step(5);
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        drain(300);
        chk(pop_cyc - prev_pop_cyc == FRAME, "b2b_pop_spacing", pop_cyc - prev_pop_cyc, FRAME);
        chk(last_gap == 1, "b2b_gap", last_gap, 1);

        // Head word changes right after the pop of 0x81.
        step(3);
        push(8'h81, 1'b1);
        push(8'h55, 1'b1);
        drain(300);

        // Enable gating: nothing starts while tx_en is low; dropping it
        // mid-frame lets 0x3C finish and leaves 0x99 in the FIFO.
        tx_en = 1'b0;
        step(3);
        snap = pop_total;
        push(8'h3C, 1'b1);
        push(8'h99, 1'b0);
        step(10);
        chk(pop_total == snap, "disabled_pops", pop_total - snap, 0);
        tx_en = 1'b1;
        wait_k(4 * CPB, "wait_bit3");
        tx_en = 1'b0;
        drain(200);
        step(60);
        chk(pop_total - snap == 1, "txen_drop_pops", pop_total - snap, 1);
        exp_q.push_back(8'h99);
        tx_en = 1'b1;
        drain(200);

        // Reset in the middle of the data bits.
        step(3);
        push(8'h5A, 1'b1);
        wait_k(3 * CPB, "wait_data");
        reset = 1'b1;
        #1;
        chk(tx == 1'b1, "midreset_tx", tx, 1);
        chk(tx_busy == 1'b0, "midreset_busy", tx_busy, 0);
        chk(fifo_rd == 1'b0, "midreset_rd", fifo_rd, 0);
        step(3);
        reset = 1'b0;
        snap = pop_total;
        step(20);
        chk(pop_total == snap, "post_reset_pops", pop_total - snap, 0);
        chk(exp_q.size() == 0, "aborted_frame_consumed", exp_q.size(), 0);
        push(8'hC3, 1'b1);
        drain(200);

        // Random traffic with random gaps.
        for (int i = 0; i < 30; i++) begin
            step($urandom_range(0, 50));
            rb = 8'($urandom);
            push(rb, 1'b1);
        end
        drain(30 * (FRAME + 5) + 200);

        // Two stop bits on the second instance.
        f2_data  = 8'h01;
        f2_empty = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 10) begin
            @(negedge clk);
            if (f2_rd) found = 1'b1;
            n++;
        end
        chk(found, "sb2_pop", found, 1);
        @(posedge clk);
        #1;
        f2_empty = 1'b1;
        w_err = 0; b_err = 0; done_n = 0; done_at = -1; stop_hi = 0; pops2 = 0;
        for (int c = 0; c < 11 * CPB; c++) begin
            @(negedge clk);
            if (tx2 !== exp_level(8'h01, c)) w_err++;
            if (!busy2) b_err++;
            if (done2) begin
                done_n++;
                done_at = c;
            end
            if (f2_rd) pops2++;
            if (c >= (1 + DW) * CPB && tx2) stop_hi++;
        end
        chk(w_err == 0, "sb2_wave_errs", w_err, 0);
        chk(stop_hi == 2 * CPB, "sb2_stop_high", stop_hi, 2 * CPB);
        chk(done_n == 1 && done_at == 11 * CPB - 1, "sb2_done_at", done_at, 11 * CPB - 1);
        chk(b_err == 0, "sb2_busy_errs", b_err, 0);
        chk(pops2 == 0, "sb2_extra_pops", pops2, 0);
        @(negedge clk);
        chk(tx2 == 1'b1 && busy2 == 1'b0, "sb2_idle_after", {tx2, busy2}, 2);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per UART frame and FIFO word.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434: clk cycles per serial bit (50 MHz / 115200), minimum 2.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port tx_en  input  1  permits starting new frames; frames in progress always complete.
REQ-007 SHALL have port fifo_empty  input  1  source FIFO empty flag.
REQ-008 SHALL have port fifo_rd_data  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty is low (show-ahead).
REQ-009 SHALL have port fifo_rd  output  1  one-cycle pop strobe to the FIFO.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port tx_busy  output  1  high from frame load through the end of the last stop bit.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse on the final cycle of the last stop bit.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP; every bit period SHALL last exactly CLKS_PER_BIT cycles.
REQ-014 In IDLE with tx_en=1 and fifo_empty=0, SHALL latch fifo_rd_data into the shift register, assert fifo_rd for exactly that one cycle, and enter START on the next edge.
REQ-015 tx SHALL be driven from a register: 1 in IDLE, 0 in START, shift_reg[0] in DATA (LSB first), 1 in STOP.
REQ-016 Latency: tx SHALL fall on the clock edge following the fifo_rd cycle.
REQ-017 DATA SHALL send exactly DATA_WIDTH bits, using a bit counter of $clog2(DATA_WIDTH) bits; STOP SHALL last STOP_BITS bit periods.
REQ-018 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and restart at 0 on every state entry, with no drift across bits.
REQ-019 At the end of STOP with tx_en=1 and fifo_empty=0, SHALL load the next word and pulse fifo_rd in that cycle, then enter START directly (no idle gap). Otherwise it SHALL return to IDLE.
REQ-020 fifo_rd SHALL never assert while fifo_empty=1, while in START or DATA, or twice within a single frame.
REQ-021 Changes to fifo_rd_data or fifo_empty after the load SHALL NOT affect the frame in progress.
REQ-022 Deasserting tx_en mid-frame SHALL let the current frame finish; no new frame SHALL start afterwards.

Reset
REQ-023 On reset, the block SHALL immediately enter IDLE with tx=1, fifo_rd=0, tx_busy=0, tx_done=0 and all counters at 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame (tx returns high at once); no pop SHALL occur while reset is high.
REQ-025 After reset release, the first fifo_rd SHALL occur no earlier than the first rising clk edge after release.

Structure
REQ-026 FSM state encoding and the default baud constant SHALL live in shared package uart_pkg, reused by the receiver.
REQ-027 A sub-module uart_baud_gen (restartable counter producing a one-cycle bit_tick) SHALL be used; shifting and FSM logic SHALL remain in uart_fifo_tx.
REQ-028 The block SHALL connect directly to fifo2: fifo_rd to read, fifo_empty to empty, fifo_rd_data to read_data.

Verification (bench: DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1)
REQ-029 Reset mid-frame: reset pulse during DATA -> tx=1 and tx_busy=0 immediately; no fifo_rd until FIFO non-empty after release.
REQ-030 Single byte: FIFO holds 0xA5, tx_en=1 -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1, each level 4 cycles; tx_done once; tx_busy high for 40 cycles.
REQ-031 Back-to-back: FIFO holds 0x00, 0xFF -> two fifo_rd pulses 40 cycles apart; the second start bit immediately follows the first stop bit.
REQ-032 Empty/enable gating: fifo_empty=1 for 100 cycles -> tx stays 1 and fifo_rd stays 0. tx_en dropped at bit 3 of 0x3C -> frame completes, and no further pop occurs with FIFO still non-empty.
REQ-033 Data hold: fifo_rd_data changed to 0x55 one cycle after the pop of 0x81 -> serialized bits still encode 0x81.
REQ-034 Two stop bits (STOP_BITS=2): 0x01 -> tx high for 8 cycles after the data bits, tx_done on the 8th.
